conv2d_engine: RTL
==================

CONV2D_ENGINE -- requirements
Module: conv2d_engine

Interface
REQ-001 SHALL have parameter DW, default 8, meaning signed feature/filter element width.
REQ-002 SHALL have parameter NMAX, default 8, meaning maximum feature-map side length.
REQ-003 SHALL have parameter K, default 3, meaning square kernel side (legal 2..4).
REQ-004 SHALL have parameter ACCW, default 2*DW+$clog2(K*K), meaning signed accumulator/output width.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  begin a job; sampled only in IDLE.
REQ-008 cfg_n  input  $clog2(NMAX+1)  feature side length n, 1..NMAX; latched on start.
REQ-009 cfg_stride  input  3  stride s, 1..4; latched on start.
REQ-010 cfg_pad  input  3  zero padding p per edge, 0..K-1; latched on start.
REQ-011 feat_valid/feat_ready/feat_data  in/out/in  1/1/DW  feature stream, n*n beats, row-major.
REQ-012 filt_valid/filt_ready/filt_data  in/out/in  1/1/DW  filter stream, K*K beats, row-major.
REQ-013 out_valid/out_ready/out_data  out/in/out  1/1/ACCW  result stream, signed.
REQ-014 out_last  output  1  high with final result of job.
REQ-015 busy, done, err  output  1 each  job active; one-cycle completion pulse; illegal config flag.

Function
REQ-016 FSM states SHALL be IDLE, LOAD_F, LOAD_W, MAC, OUT, FIN.
REQ-017 IDLE->LOAD_F on start; start while not IDLE SHALL be ignored.
REQ-018 If n+2p<K, stride 0, or n>NMAX at start: err=1, no beats accepted, FIN next cycle; err clears on next start.
REQ-019 feat_ready SHALL be high only in LOAD_F; beat stored when feat_valid&feat_ready; LOAD_F->LOAD_W after beat n*n.
REQ-020 filt_ready SHALL be high only in LOAD_W; LOAD_W->MAC after beat K*K; source stalls tolerated indefinitely.
REQ-021 Output grid side O=floor((n+2p-K)/s)+1; results emitted row-major, O*O total.
REQ-022 Taps falling in padding region SHALL contribute exactly zero; no padded array stored.
REQ-023 Products SHALL be full signed DW x DW (2*DW bits), sign-extended, summed into ACCW signed, no saturation.
REQ-024 MAC issues one tap per cycle (K*K cycles), one pipeline stage; out_valid asserted exactly K*K+2 cycles after MAC entry.
REQ-025 In OUT, out_data/out_last SHALL hold stable while out_valid&!out_ready; on accept go to MAC (next window, accumulator cleared) or FIN after last.
REQ-026 FIN SHALL pulse done one cycle, then IDLE; busy high in every state except IDLE.
REQ-027 Stored feature and filter SHALL persist in IDLE; not cleared by job completion.

Reset
REQ-028 rst SHALL immediately force IDLE; out_valid, out_last, feat_ready, filt_ready, busy, done, err=0; out_data=0; counters=0.
REQ-029 rst mid-job SHALL abandon the job; no partial result emitted after release.
REQ-030 Storage arrays need not be reset.

Structure
REQ-031 Package conv_pkg SHALL hold FSM state enum, clog2-derived width constants, and default DW/K/NMAX.
REQ-032 One sub-module conv_mac SHALL implement registered signed multiply plus accumulate with clear and enable.
REQ-033 Window/tap address and pad-detection logic SHALL stay in conv2d_engine.

Verification
REQ-034 K=2, n=3, s=1, p=0, feature 1..9, filter [1,0,0,1] -> outputs 6,8,12,14; out_last on 14; done one cycle after.
REQ-035 K=2, n=3, s=1, p=1, all ones -> 16 outputs 1,2,2,1,2,4,4,2,2,4,4,2,1,2,2,1.
REQ-036 K=2, n=4, s=2, p=0, feature 0..15, filter [1,0,0,0] -> outputs 0,2,8,10.
REQ-037 K=2, n=2, all elements -128 -> single output +65536 (ACCW=18).
REQ-038 out_ready low 5 cycles on first result -> out_data stable, no result lost or duplicated.
REQ-039 rst pulse during MAC -> outputs zero same cycle, IDLE; fresh job afterwards yields REQ-034 values; K=2, n=1, p=0 -> err=1, done, zero outputs.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the conv2d engine.
//   - default element width, kernel side and maximum feature side
//   - configuration field widths and a small width helper
//   - FSM state type used by conv2d_engine
package conv_pkg;

  localparam int DEF_DW   = 8;
  localparam int DEF_NMAX = 8;
  localparam int DEF_K    = 3;
  localparam int DEF_NW   = $clog2(DEF_NMAX + 1);

  localparam int STRIDE_W = 3;
  localparam int PAD_W    = 3;

  // Bits needed to index 0..v-1, never less than one.
  function automatic int cnt_w(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    LOAD_F,
    LOAD_W,
    MAC,
    OUT,
    FIN
  } conv_state_t;

endpackage

// File: rtl/conv_mac.sv
// conv_mac: registered signed multiply followed by signed accumulate.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : zero the accumulator (takes priority)
//   en       : a*b is a valid tap this cycle; product registered, added next cycle
//   a, b     : signed DW-bit operands
//   acc      : signed ACCW-bit running sum, wraps without saturation
module conv_mac #(
  parameter int DW   = 8,
  parameter int ACCW = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [ACCW-1:0] acc
);

  logic signed [2*DW-1:0] prod_q;
  logic                   prod_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      prod_v <= 1'b0;
      acc    <= '0;
    end else begin
      prod_v <= en;
      if (en) begin
        prod_q <= a * b;
      end
      if (clr) begin
        acc <= '0;
      end else if (prod_v) begin
        acc <= acc + ACCW'(prod_q);
      end
    end
  end

endmodule

// File: rtl/conv2d_engine.sv
// conv2d_engine: single-job 2-D convolution of an n x n signed feature map
// with a K x K signed filter, stride s and zero padding p.
//   clk, rst                      : clock, asynchronous active-high reset
//   start, cfg_n/stride/pad       : job launch and configuration (sampled in IDLE)
//   feat_valid/ready/data         : n*n feature beats, row-major
//   filt_valid/ready/data         : K*K filter beats, row-major
//   out_valid/ready/data, out_last: O*O signed results, row-major
//   busy, done, err               : job active, completion pulse, illegal config
module conv2d_engine
  import conv_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NMAX = DEF_NMAX,
  parameter int K    = DEF_K,
  parameter int ACCW = 2*DW + $clog2(K*K)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(NMAX+1)-1:0]    cfg_n,
  input  logic [STRIDE_W-1:0]          cfg_stride,
  input  logic [PAD_W-1:0]             cfg_pad,
  input  logic                         feat_valid,
  output logic                         feat_ready,
  input  logic signed [DW-1:0]         feat_data,
  input  logic                         filt_valid,
  output logic                         filt_ready,
  input  logic signed [DW-1:0]         filt_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACCW-1:0]       out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int NW   = $clog2(NMAX + 1);
  localparam int KK   = K * K;
  localparam int AW   = cnt_w(NMAX * NMAX);
  localparam int KAW  = cnt_w(KK);
  localparam int CNTW = (AW > KAW) ? AW : KAW;
  localparam int MW   = cnt_w(KK + 2);
  localparam int KW   = cnt_w(K);
  localparam int CW   = 2*NW + 4;

  conv_state_t state, next_state;

  logic [NW-1:0]       n_q;
  logic [STRIDE_W-1:0] s_q;
  logic [PAD_W-1:0]    p_q;
  logic [CNTW-1:0]     cnt;
  logic [MW-1:0]       mc;
  logic [KW-1:0]       kr, kc;
  logic [CW-1:0]       wx, wy;
  logic                last_q;

  logic signed [DW-1:0] feat_mem [NMAX*NMAX];
  logic signed [DW-1:0] filt_mem [KK];

  logic                   cfg_bad, last_feat, last_filt, mac_done;
  logic                   tap_en, tap_pad, last_col, last_row, clr;
  logic [CW-1:0]          rr, cc, pp, hi, ext;
  logic [AW-1:0]          feat_addr;
  logic signed [DW-1:0]   tap_a, tap_b;
  logic signed [ACCW-1:0] acc;

  assign cfg_bad = (cfg_n == '0) || (CW'(cfg_n) > CW'(NMAX)) || (cfg_stride == '0) ||
                   (CW'(cfg_n) + (CW'(cfg_pad) << 1) < CW'(K));

  assign last_feat = (CW'(cnt) + CW'(1) == CW'(n_q) * CW'(n_q));
  assign last_filt = (cnt == CNTW'(KK - 1));
  assign mac_done  = (mc == MW'(KK + 1));
  assign tap_en    = (state == MAC) && (mc < MW'(KK));

  // Window origin (wx, wy) lives in padded coordinates; a tap is padding when
  // it lands outside [p, n+p) on either axis, so no padded copy is stored.
  always_comb begin
    pp        = CW'(p_q);
    hi        = CW'(n_q) + pp;
    ext       = CW'(n_q) + (pp << 1);
    rr        = wy + CW'(kr);
    cc        = wx + CW'(kc);
    tap_pad   = (rr < pp) || (rr >= hi) || (cc < pp) || (cc >= hi);
    feat_addr = AW'((rr - pp) * CW'(n_q) + (cc - pp));
    tap_a     = tap_pad ? '0 : feat_mem[feat_addr];
    tap_b     = filt_mem[KAW'(mc)];
    last_col  = (wx + CW'(s_q) + CW'(K) > ext);
    last_row  = (wy + CW'(s_q) + CW'(K) > ext);
  end

  assign clr = ((state == LOAD_W) && filt_valid && last_filt) ||
               ((state == OUT) && out_ready && !last_q);

  conv_mac #(.DW(DW), .ACCW(ACCW)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (tap_en),
    .a   (tap_a),
    .b   (tap_b),
    .acc (acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (start) next_state = cfg_bad ? FIN : LOAD_F;
      LOAD_F: if (feat_valid && last_feat) next_state = LOAD_W;
      LOAD_W: if (filt_valid && last_filt) next_state = MAC;
      MAC:    if (mac_done) next_state = OUT;
      OUT:    if (out_ready) next_state = last_q ? FIN : MAC;
      FIN:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign feat_ready = (state == LOAD_F);
  assign filt_ready = (state == LOAD_W);
  assign out_valid  = (state == OUT);
  assign out_last   = (state == OUT) && last_q;
  assign busy       = (state != IDLE);
  assign done       = (state == FIN);

  always_ff @(posedge clk) begin
    if ((state == LOAD_F) && feat_valid) feat_mem[AW'(cnt)] <= feat_data;
    if ((state == LOAD_W) && filt_valid) filt_mem[KAW'(cnt)] <= filt_data;
  end

  // MAC spends KK+2 cycles per window: KK tap issues, then one cycle for the
  // product register and one for the final accumulate before capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q      <= '0;
      s_q      <= '0;
      p_q      <= '0;
      cnt      <= '0;
      mc       <= '0;
      kr       <= '0;
      kc       <= '0;
      wx       <= '0;
      wy       <= '0;
      last_q   <= 1'b0;
      out_data <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          n_q <= cfg_n;
          s_q <= cfg_stride;
          p_q <= cfg_pad;
          err <= cfg_bad;
          cnt <= '0;
          mc  <= '0;
          kr  <= '0;
          kc  <= '0;
          wx  <= '0;
          wy  <= '0;
        end
        LOAD_F: if (feat_valid) cnt <= last_feat ? '0 : cnt + CNTW'(1);
        LOAD_W: if (filt_valid) cnt <= last_filt ? '0 : cnt + CNTW'(1);
        MAC: begin
          if (mac_done) begin
            mc       <= '0;
            out_data <= acc;
            last_q   <= last_col && last_row;
          end else begin
            mc <= mc + MW'(1);
          end
          if (tap_en) begin
            if (kc == KW'(K - 1)) begin
              kc <= '0;
              kr <= (kr == KW'(K - 1)) ? '0 : kr + KW'(1);
            end else begin
              kc <= kc + KW'(1);
            end
          end
        end
        OUT: if (out_ready) begin
          if (last_col) begin
            wx <= '0;
            wy <= wy + CW'(s_q);
          end else begin
            wx <= wx + CW'(s_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
